int_sched: RTL and testbench
============================

Name: int_sched

Overview:
- Interrupt scheduler between the interrupt controller's request lines (doorbell, external pin, timer, others) and the processor pipeline.
- Selects one enabled pending source by fixed priority and presents a redirect vector to the pipeline.
- Completes the per-source acknowledge handshake, then blocks further dispatch until the handler returns (rfi).
- Aborts cleanly on request withdrawal, on MSR[EE] clear, or on a dispatch timeout.

Parameters:
- NUM_SRC, 4, number of interrupt sources; index 0 is the highest priority.
- ADDR_W, 32, vector/address width.
- VEC_SHIFT, 4, log2 of the byte spacing between handler vectors.
- TIMEOUT, 64, cycles allowed from dispatch to pipeline accept before abort; must be ≥ 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- src_req  in  NUM_SRC  level requests; each is held by its source until acked.
- src_mask  in  NUM_SRC  1 = source enabled.
- msr_ee  in  1  global external-interrupt enable.
- ivbase  in  ADDR_W  vector base address.
- int_accept  in  1  pipeline has taken the redirect this cycle.
- rfi  in  1  return-from-interrupt retired.
- int_valid  out  1  dispatch request to the pipeline.
- int_vector  out  ADDR_W  handler address.
- int_cause  out  $clog2(NUM_SRC)  index of the winning source.
- src_ack  out  NUM_SRC  one-hot acknowledge pulse.
- busy  out  1  a handler is in progress.
- timeout_err  out  1  sticky; set on dispatch timeout.

Behaviour:
- Reset (asynchronous, any state): state=S_IDLE, int_valid=0, int_vector=0, int_cause=0, src_ack=0, busy=0, timeout_err=0, timeout counter=0.
- Winner selection: pend = src_req & src_mask. The winner is the lowest set index, chosen combinationally.
- S_IDLE:
  - If msr_ee && |pend: latch win_idx and vector = ivbase + (win_idx << VEC_SHIFT), truncated modulo 2^ADDR_W. Clear the counter and go to S_DISPATCH.
  - Decision to int_valid is 1 cycle.
- S_DISPATCH:
  - int_valid=1; int_vector and int_cause hold the latched values, frozen even if a higher-priority request arrives.
  - Counter increments each cycle.
  - Transition priority, highest first:
    - int_accept → S_ACK. Accept wins over a same-cycle withdrawal or EE clear.
    - !msr_ee, or !src_req[win_idx] → S_IDLE with no ack.
    - Counter == TIMEOUT-1 → S_IDLE and set timeout_err.
- S_ACK:
  - One cycle. src_ack[win_idx]=1, busy=1, int_valid=0. Next state is S_ACTIVE.
  - The source drops its request on the following cycle.
- S_ACTIVE:
  - busy=1. src_req and msr_ee are ignored, so there is no nesting.
  - rfi → S_IDLE. A new dispatch may start in the cycle after returning to S_IDLE.
- rfi outside S_ACTIVE is ignored. int_accept outside S_DISPATCH is ignored.
- A request asserted and withdrawn entirely while in S_ACTIVE is lost; sources must hold requests.
- timeout_err clears only on reset.
- In S_UNDEF, all outputs are x; the default branch of the state machine goes to S_UNDEF.
- Latencies:
  - req→int_valid: 1 cycle.
  - accept→src_ack: 1 cycle.
  - rfi→S_IDLE: 1 cycle.

Decomposition:
- Pu_types holds:
  - the Int_sched_state enum, one-hot: S_IDLE, S_DISPATCH, S_ACK, S_ACTIVE, with S_UNDEF = x.
  - source index constants: INT_SRC_DOORBELL=0, INT_SRC_EXT=1, INT_SRC_TIMER=2, INT_SRC_OTHER=3.
  - the NUM_INT_SRC constant.
- One sub-module, int_prio_enc: parameterised lowest-index-first priority encoder that outputs any_valid and idx.

Test Plan:
- Single request: src_mask=4'b1111, msr_ee=1, ivbase=0x1000, src_req=4'b0100 → int_valid next cycle with vector 0x1020 and cause 2. Accept → src_ack=4'b0100 for exactly 1 cycle, busy=1. rfi → back to idle.
- Simultaneous requests: src_req=4'b1010 → cause 1, vector 0x1010. Raising src_req[0] during S_DISPATCH does not change the vector. After rfi, with src_req=4'b1001, cause 0 is dispatched.
- Masking and EE: src_mask=4'b1110 with src_req=4'b0001 → no int_valid. msr_ee=0 with src_req=4'b0010 → no dispatch. Dropping msr_ee in S_DISPATCH → int_valid low next cycle, no src_ack.
- Withdrawal vs accept: src_req[2] drops while int_valid and no accept → abort, no ack. Repeat with the drop and int_accept in the same cycle → src_ack[2] asserted.
- Timeout: TIMEOUT=64, int_accept held low → int_valid high for exactly 64 cycles, then 0 and timeout_err=1. timeout_err stays 1 across later dispatches until reset.
- Reset and wrap: assert reset in S_ACTIVE → all outputs 0 immediately, asynchronously. Separately, ivbase=0xFFFFFFF0 with cause 3 → vector 0x00000020.

Source files
------------

// File: rtl/int_sched_pkg.sv
// rtl/int_sched_pkg.sv - shared types and constants for the interrupt scheduler
package int_sched_pkg;

  localparam int NUM_INT_SRC      = 4;

  localparam int INT_SRC_DOORBELL = 0;
  localparam int INT_SRC_EXT      = 1;
  localparam int INT_SRC_TIMER    = 2;
  localparam int INT_SRC_OTHER    = 3;

  // One-hot encoding; S_UNDEF lets an illegal state propagate as x in simulation.
  typedef enum logic [3:0] {
    S_IDLE     = 4'b0001,
    S_DISPATCH = 4'b0010,
    S_ACK      = 4'b0100,
    S_ACTIVE   = 4'b1000,
    S_UNDEF    = 4'bxxxx
  } int_sched_state_e;

endpackage

// File: rtl/int_sched_if.sv
// rtl/int_sched_if.sv - source/pipeline signal bundle for the interrupt scheduler
interface int_sched_if
  import int_sched_pkg::*;
#(
  parameter int NUM_SRC = NUM_INT_SRC,
  parameter int ADDR_W  = 32
);
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] src_req;
  logic [NUM_SRC-1:0] src_mask;
  logic               msr_ee;
  logic [ADDR_W-1:0]  ivbase;
  logic               int_accept;
  logic               rfi;
  logic               int_valid;
  logic [ADDR_W-1:0]  int_vector;
  logic [IDX_W-1:0]   int_cause;
  logic [NUM_SRC-1:0] src_ack;
  logic               busy;
  logic               timeout_err;

  modport slave (
    input  src_req, src_mask, msr_ee, ivbase, int_accept, rfi,
    output int_valid, int_vector, int_cause, src_ack, busy, timeout_err
  );

  modport master (
    output src_req, src_mask, msr_ee, ivbase, int_accept, rfi,
    input  int_valid, int_vector, int_cause, src_ack, busy, timeout_err
  );
endinterface

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - lowest-index-first priority encoder
module int_prio_enc
  import int_sched_pkg::*;
#(
  parameter int N     = NUM_INT_SRC,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             any_valid,
  output logic [IDX_W-1:0] idx
);

  assign any_valid = |req;

  // Scan downward so the lowest set index is the last (winning) assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/int_sched.sv
// rtl/int_sched.sv - fixed-priority interrupt scheduler with ack handshake and dispatch timeout
module int_sched
  import int_sched_pkg::*;
#(
  parameter int NUM_SRC   = NUM_INT_SRC,
  parameter int ADDR_W    = 32,
  parameter int VEC_SHIFT = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        reset,
  int_sched_if.slave  bus
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  int_sched_state_e   state, next;
  logic [IDX_W-1:0]   idx_q;
  logic [ADDR_W-1:0]  vec_q;
  logic [CNT_W-1:0]   cnt;
  logic               err_q;

  logic [NUM_SRC-1:0] pend;
  logic               any_pend;
  logic [IDX_W-1:0]   win_idx;
  logic               start;
  logic               timeout_hit;

  logic               valid_c;
  logic [ADDR_W-1:0]  vector_c;
  logic [IDX_W-1:0]   cause_c;
  logic [NUM_SRC-1:0] ack_c;
  logic               busy_c;
  logic               err_c;

  assign pend = bus.src_req & bus.src_mask;

  int_prio_enc #(.N(NUM_SRC), .IDX_W(IDX_W)) u_enc (
    .req       (pend),
    .any_valid (any_pend),
    .idx       (win_idx)
  );

  assign start = (state == S_IDLE) && bus.msr_ee && any_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx_q <= '0;
      vec_q <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= next;
      if (start) begin
        idx_q <= win_idx;
        vec_q <= bus.ivbase + (ADDR_W'(win_idx) << VEC_SHIFT);
        cnt   <= '0;
      end else if (state == S_DISPATCH) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  always_comb begin
    next        = state;
    timeout_hit = 1'b0;
    valid_c     = 1'b0;
    vector_c    = vec_q;
    cause_c     = idx_q;
    ack_c       = '0;
    busy_c      = 1'b0;
    err_c       = err_q;
    case (state)
      S_IDLE: begin
        if (start) next = S_DISPATCH;
      end
      S_DISPATCH: begin
        valid_c = 1'b1;
        // Accept outranks a same-cycle withdrawal, EE drop or timeout.
        if (bus.int_accept) begin
          next = S_ACK;
        end else if (!bus.msr_ee || !bus.src_req[idx_q]) begin
          next = S_IDLE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          next        = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_ACK: begin
        ack_c  = NUM_SRC'(1) << idx_q;
        busy_c = 1'b1;
        next   = S_ACTIVE;
      end
      S_ACTIVE: begin
        busy_c = 1'b1;
        if (bus.rfi) next = S_IDLE;
      end
      default: begin
        next     = S_UNDEF;
        valid_c  = 1'bx;
        vector_c = 'x;
        cause_c  = 'x;
        ack_c    = 'x;
        busy_c   = 1'bx;
        err_c    = 1'bx;
      end
    endcase
  end

  assign bus.int_valid   = valid_c;
  assign bus.int_vector  = vector_c;
  assign bus.int_cause   = cause_c;
  assign bus.src_ack     = ack_c;
  assign bus.busy        = busy_c;
  assign bus.timeout_err = err_c;

endmodule

// File: tb/tb_int_sched.sv
// tb/tb_int_sched.sv - directed self-checking bench for int_sched with a dispatch scoreboard
module tb_int_sched;
  import int_sched_pkg::*;

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] vector;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t sb[$];

  int_sched_if #(.NUM_SRC(4), .ADDR_W(32)) bus ();

  int_sched #(.NUM_SRC(4), .ADDR_W(32), .VEC_SHIFT(4), .TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int cause, input logic [31:0] base);
    exp_t e;
    e.cause  = 2'(cause);
    e.vector = base + (32'(cause) << 4);
    sb.push_back(e);
  endtask

  // One cycle after the request becomes visible the DUT must be presenting the scoreboard head.
  task automatic dispatch_check(input string tag);
    exp_t e;
    tick();
    chk({tag, "_valid"}, 64'(bus.int_valid), 64'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_cause"}, 64'(bus.int_cause), 64'(e.cause));
      chk({tag, "_vector"}, 64'(bus.int_vector), 64'(e.vector));
    end
  endtask

  task automatic finish_handler(input string tag, input int idx);
    bus.int_accept = 1'b1;
    tick();
    bus.int_accept = 1'b0;
    chk({tag, "_ack"}, 64'(bus.src_ack), 64'(4'b0001 << idx));
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    bus.src_req[idx] = 1'b0;
    tick();
    chk({tag, "_ack_pulse"}, 64'(bus.src_ack), 64'd0);
    bus.rfi = 1'b1;
    tick();
    bus.rfi = 1'b0;
    chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int n;
    bus.src_req    = '0;
    bus.src_mask   = '0;
    bus.msr_ee     = 1'b0;
    bus.ivbase     = '0;
    bus.int_accept = 1'b0;
    bus.rfi        = 1'b0;
    #3;
    chk("rst_valid", 64'(bus.int_valid), 64'd0);
    chk("rst_vector", 64'(bus.int_vector), 64'd0);
    chk("rst_cause", 64'(bus.int_cause), 64'd0);
    chk("rst_ack", 64'(bus.src_ack), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_err", 64'(bus.timeout_err), 64'd0);
    tick();
    reset = 1'b0;

    // Single request from the timer source
    bus.src_mask = 4'b1111;
    bus.msr_ee   = 1'b1;
    bus.ivbase   = 32'h1000;
    bus.src_req  = 4'b0100;
    push_exp(INT_SRC_TIMER, 32'h1000);
    dispatch_check("single");
    finish_handler("single", INT_SRC_TIMER);

    // Simultaneous requests; the vector stays frozen when a higher source arrives
    bus.src_req = 4'b1010;
    push_exp(INT_SRC_EXT, 32'h1000);
    dispatch_check("simul");
    bus.src_req[0] = 1'b1;
    tick();
    chk("frozen_cause", 64'(bus.int_cause), 64'd1);
    chk("frozen_vector", 64'(bus.int_vector), 64'h1010);
    bus.int_accept = 1'b1;
    tick();
    bus.int_accept = 1'b0;
    chk("simul_ack", 64'(bus.src_ack), 64'b0010);
    bus.src_req = 4'b1001;
    tick();
    chk("active_no_nest", 64'(bus.int_valid), 64'd0);
    bus.rfi = 1'b1;
    tick();
    bus.rfi = 1'b0;
    push_exp(INT_SRC_DOORBELL, 32'h1000);
    dispatch_check("after_rfi");
    bus.src_req[3] = 1'b0;
    finish_handler("after_rfi", INT_SRC_DOORBELL);

    // Masking and EE
    bus.src_mask = 4'b1110;
    bus.src_req  = 4'b0001;
    repeat (3) tick();
    chk("masked", 64'(bus.int_valid), 64'd0);
    bus.src_mask = 4'b1111;
    bus.msr_ee   = 1'b0;
    bus.src_req  = 4'b0010;
    repeat (3) tick();
    chk("ee_off", 64'(bus.int_valid), 64'd0);
    bus.msr_ee = 1'b1;
    push_exp(INT_SRC_EXT, 32'h1000);
    dispatch_check("ee_on");
    bus.msr_ee = 1'b0;
    tick();
    chk("ee_drop_valid", 64'(bus.int_valid), 64'd0);
    chk("ee_drop_ack", 64'(bus.src_ack), 64'd0);
    bus.src_req = 4'b0000;
    bus.msr_ee  = 1'b1;
    tick();

    // Withdrawal without accept aborts; withdrawal with accept still acks
    bus.src_req = 4'b0100;
    push_exp(INT_SRC_TIMER, 32'h1000);
    dispatch_check("wd");
    bus.src_req = 4'b0000;
    tick();
    chk("wd_valid", 64'(bus.int_valid), 64'd0);
    chk("wd_ack", 64'(bus.src_ack), 64'd0);
    bus.src_req = 4'b0100;
    push_exp(INT_SRC_TIMER, 32'h1000);
    dispatch_check("wd_acc");
    bus.src_req    = 4'b0000;
    bus.int_accept = 1'b1;
    tick();
    bus.int_accept = 1'b0;
    chk("wd_acc_ack", 64'(bus.src_ack), 64'b0100);
    tick();
    bus.rfi = 1'b1;
    tick();
    bus.rfi = 1'b0;
    chk("wd_acc_idle", 64'(bus.busy), 64'd0);

    // Timeout: int_valid held for exactly TIMEOUT cycles
    chk("pre_to_err", 64'(bus.timeout_err), 64'd0);
    bus.src_req = 4'b0100;
    push_exp(INT_SRC_TIMER, 32'h1000);
    dispatch_check("to");
    n = 1;
    while (bus.int_valid && n < 200) begin
      tick();
      if (bus.int_valid) n++;
    end
    chk("to_cycles", 64'(n), 64'd64);
    chk("to_err", 64'(bus.timeout_err), 64'd1);
    push_exp(INT_SRC_TIMER, 32'h1000);
    dispatch_check("to_redispatch");
    chk("to_err_sticky", 64'(bus.timeout_err), 64'd1);
    finish_handler("to_done", INT_SRC_TIMER);
    chk("to_err_sticky2", 64'(bus.timeout_err), 64'd1);

    // Asynchronous reset while a handler is active
    bus.src_req = 4'b0001;
    push_exp(INT_SRC_DOORBELL, 32'h1000);
    dispatch_check("ar");
    bus.int_accept = 1'b1;
    tick();
    bus.int_accept = 1'b0;
    bus.src_req    = 4'b0000;
    tick();
    chk("ar_busy_pre", 64'(bus.busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_busy", 64'(bus.busy), 64'd0);
    chk("ar_err", 64'(bus.timeout_err), 64'd0);
    chk("ar_valid", 64'(bus.int_valid), 64'd0);
    chk("ar_vector", 64'(bus.int_vector), 64'd0);
    chk("ar_cause", 64'(bus.int_cause), 64'd0);
    tick();
    reset = 1'b0;

    // Vector wraps modulo 2^ADDR_W
    bus.ivbase  = 32'hFFFF_FFF0;
    bus.src_req = 4'b1000;
    push_exp(INT_SRC_OTHER, 32'hFFFF_FFF0);
    dispatch_check("wrap");
    chk("wrap_abs", 64'(bus.int_vector), 64'h20);
    finish_handler("wrap", INT_SRC_OTHER);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
